digit_scan_ctrl: RTL and testbench

Time-multiplexed scan sequencer that sits directly upstream of the 2-to-4 one-hot decoder in the display path. It divides the system clock into a scan rate, steps a 2-bit digit select through four positions (skipping masked-off positions), and presents the selected 4-bit digit code. The 2-bit `sel` output drives the decoder's select input, and the decoder's one-hot output drives the digit enables. `nibble` and `blank` feed the segment path in the same cycle as `sel`.

---
 rtl/scan_pkg.sv | 28 ++
 rtl/scan_prescaler.sv | 36 +++
 rtl/digit_scan_ctrl.sv | 88 ++++++++
 tb/tb_digit_scan_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types, constants and the masked next-digit search for the display scan sequencer.
package scan_pkg;

    typedef logic [1:0] sel_t;

    localparam int NUM_DIGITS    = 4;
    localparam int DIV_W_DEFAULT = 16;

    // First enabled position after cur (cur+1, cur+2, cur+3, cur itself); holds cur when mask is empty.
    function automatic sel_t next_enabled(sel_t cur, logic [3:0] mask);
        sel_t res;
        sel_t cand;
        logic found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            cand = cur + sel_t'(k);
            if (!found && mask[cand]) begin
                res   = cand;
                found = 1'b1;
            end else begin
                res   = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Scan-rate prescaler: counts system clocks and flags a step every div_val+1 enabled cycles.
module scan_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    output logic             step
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_wrap;

    // Using >= lets a shrinking div_val force an immediate step rather than waiting for a counter wrap.
    always_comb begin
        w_wrap = (r_cnt >= div_val);
        step   = en & w_wrap;
    end

    // Counter advances only while enabled and restarts after each step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {DIV_W{1'b0}};
        end else if (en) begin
            if (w_wrap) begin
                r_cnt <= {DIV_W{1'b0}};
            end else begin
                r_cnt <= r_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scan sequencer; sel feeds an external 2-to-4 decoder, nibble/blank the segment path.
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic [3:0]       mask,
    input  logic [15:0]      digits,
    input  logic             load,
    output logic [1:0]       sel,
    output logic [3:0]       nibble,
    output logic             blank,
    output logic             tick
);

    logic        w_step;
    sel_t        w_sel_next;
    logic [15:0] w_src;
    logic [3:0]  w_nib_next;
    logic        w_blank_next;
    logic [15:0] r_shadow;
    sel_t        r_sel;
    logic [3:0]  r_nibble;
    logic        r_blank;
    logic        r_tick;

    scan_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_val (div_val),
        .step    (w_step)
    );

    // Next select, nibble source (incoming digits bypass the shadow when load and step coincide) and blank.
    always_comb begin
        w_sel_next   = r_sel;
        w_src        = r_shadow;
        w_nib_next   = r_nibble;
        if (w_step) begin
            w_sel_next = next_enabled(r_sel, mask);
        end else begin
            w_sel_next = r_sel;
        end
        if (load) begin
            w_src = digits;
        end else begin
            w_src = r_shadow;
        end
        if (w_step) begin
            w_nib_next = w_src[{w_sel_next, 2'b00} +: 4];
        end else begin
            w_nib_next = r_nibble;
        end
        w_blank_next = ~en | (mask == 4'b0000) | ~mask[w_sel_next];
    end

    // Output and shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= 16'h0000;
            r_sel    <= 2'd0;
            r_nibble <= 4'h0;
            r_blank  <= 1'b1;
            r_tick   <= 1'b0;
        end else begin
            if (load) begin
                r_shadow <= digits;
            end else begin
                r_shadow <= r_shadow;
            end
            r_sel    <= w_sel_next;
            r_nibble <= w_nib_next;
            r_blank  <= w_blank_next;
            r_tick   <= w_step;
        end
    end

    assign sel    = r_sel;
    assign nibble = r_nibble;
    assign blank  = r_blank;
    assign tick   = r_tick;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: a reference model pushes expected outputs, sampled results are popped and compared.
module tb_digit_scan_ctrl;

    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] div_val;
    logic [3:0]    mask;
    logic [15:0]   digits;
    logic          load;
    logic [1:0]    sel;
    logic [3:0]    nibble;
    logic          blank;
    logic          tick;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] nibble;
        logic       blank;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_cnt;
    logic [1:0]    m_sel;
    logic [3:0]    m_nib;
    logic [15:0]   m_shadow;
    logic          m_blank;
    logic          m_tick;

    digit_scan_ctrl #(.DIV_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_val (div_val),
        .mask    (mask),
        .digits  (digits),
        .load    (load),
        .sel     (sel),
        .nibble  (nibble),
        .blank   (blank),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt    = '0;
        m_sel    = 2'd0;
        m_nib    = 4'h0;
        m_shadow = 16'h0000;
        m_blank  = 1'b1;
        m_tick   = 1'b0;
    endtask

    // Advance the reference model by one edge using the current inputs and queue its outputs.
    task automatic model_push();
        logic       stp;
        logic [1:0] nsel;
        logic [1:0] idx;
        logic [15:0] src;
        exp_t e;
        stp  = en && (m_cnt >= div_val);
        nsel = m_sel;
        if (stp && mask != 4'b0000) begin
            for (int k = 4; k >= 1; k--) begin
                idx = 2'((int'(m_sel) + k) % 4);
                if (mask[idx]) nsel = idx;
            end
        end
        if (en) m_cnt = (m_cnt >= div_val) ? '0 : m_cnt + 16'd1;
        src = load ? digits : m_shadow;
        if (stp) m_nib = 4'((src >> (4 * int'(nsel))) & 16'h000F);
        m_blank = !en || (mask == 4'b0000) || !mask[nsel];
        if (load) m_shadow = digits;
        m_sel  = nsel;
        m_tick = stp;
        e.sel = m_sel; e.nibble = m_nib; e.blank = m_blank; e.tick = m_tick;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            model_push();
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("sb_sel",    32'(sel),    32'(e.sel));
            chk("sb_nibble", 32'(nibble), 32'(e.nibble));
            chk("sb_blank",  32'(blank),  32'(e.blank));
            chk("sb_tick",   32'(tick),   32'(e.tick));
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sel"},    32'(sel),    32'd0);
        chk({tag, "_nibble"}, 32'(nibble), 32'd0);
        chk({tag, "_blank"},  32'(blank),  32'd1);
        chk({tag, "_tick"},   32'(tick),   32'd0);
    endtask

    initial begin
        int guard;
        rst_n = 1'b1; en = 1'b0; div_val = 16'd3; mask = 4'hF; digits = 16'h0000; load = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst");
        model_reset();

        // Full-mask scan with load on the first cycle after release
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1; load = 1'b1; digits = 16'h4321;
        cyc(1);
        load = 1'b0; digits = 16'h0000;
        cyc(2);
        chk("full_pre_tick", 32'(tick), 32'd0);
        chk("full_pre_sel",  32'(sel),  32'd0);
        cyc(1);
        chk("full_s1_tick", 32'(tick),   32'd1);
        chk("full_s1_sel",  32'(sel),    32'd1);
        chk("full_s1_nib",  32'(nibble), 32'h2);
        cyc(1);
        chk("full_tick_w",  32'(tick),   32'd0);
        cyc(3);
        chk("full_s2_sel",  32'(sel),    32'd2);
        chk("full_s2_nib",  32'(nibble), 32'h3);
        cyc(4);
        chk("full_s3_sel",  32'(sel),    32'd3);
        chk("full_s3_nib",  32'(nibble), 32'h4);
        cyc(4);
        chk("full_s4_sel",  32'(sel),    32'd0);
        chk("full_s4_nib",  32'(nibble), 32'h1);
        chk("full_blank",   32'(blank),  32'd0);

        // Sparse mask, step every cycle
        mask = 4'b1010; div_val = 16'd0;
        cyc(1); chk("sparse_a", 32'(sel), 32'd1);
        cyc(1); chk("sparse_b", 32'(sel), 32'd3);
        cyc(1); chk("sparse_c", 32'(sel), 32'd1);
        chk("sparse_blank", 32'(blank), 32'd0);

        // Empty mask holds sel and blanks; single-bit mask parks on that digit
        mask = 4'b0000;
        cyc(1);
        chk("mask0_sel",   32'(sel),   32'd1);
        chk("mask0_blank", 32'(blank), 32'd1);
        mask = 4'b0100;
        cyc(1);
        chk("mask4_sel",   32'(sel),   32'd2);
        chk("mask4_blank", 32'(blank), 32'd0);
        cyc(2);
        chk("mask4_hold",  32'(sel),   32'd2);

        // Load coinciding with a step to digit 2 bypasses the shadow
        load = 1'b1; digits = 16'hABCD;
        cyc(1);
        chk("coll_nib", 32'(nibble), 32'hB);
        load = 1'b0;
        div_val = 16'd10;
        load = 1'b1; digits = 16'h1234;
        cyc(1);
        load = 1'b0;
        chk("load_nostep_nib", 32'(nibble), 32'hB);

        // Shrinking div_val below the running count forces an immediate step
        mask = 4'hF; div_val = 16'd100;
        guard = 0;
        while (m_cnt != 16'd50 && guard < 300) begin
            cyc(1);
            guard++;
        end
        chk("shrink_reach50", 32'(m_cnt), 32'd50);
        div_val = 16'd5;
        cyc(1); chk("shrink_step", 32'(tick), 32'd1);
        cyc(5); chk("shrink_gap",  32'(tick), 32'd0);
        cyc(1); chk("shrink_next", 32'(tick), 32'd1);

        // Disable mid-period freezes count and sel, then resumes
        cyc(2);
        en = 1'b0;
        cyc(1);
        chk("en0_blank", 32'(blank), 32'd1);
        cyc(8);
        chk("en0_tick",  32'(tick),  32'd0);
        en = 1'b1;
        cyc(8);

        // Asynchronous reset mid-period
        cyc(2);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(8);

        // Randomised traffic through the scoreboard
        for (int i = 0; i < 300; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            mask    = 4'($urandom_range(0, 15));
            div_val = 16'($urandom_range(0, 3));
            load    = ($urandom_range(0, 3) == 0);
            digits  = 16'($urandom);
            cyc(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
